// File: rtl/time_request_sequencer_pkg.sv
// Shared types and constants for the time request sequencer: field widths,
// field maxima, request bit positions and the alarm state encoding.
package clock_pkg;

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnoozed = 2'd3
    } alarm_state_e;

    localparam int unsigned SecW = 6;
    localparam int unsigned MinW = 6;
    localparam int unsigned HrsW = 4;

    localparam logic [SecW-1:0] MaxSec = 6'd59;
    localparam logic [MinW-1:0] MaxMin = 6'd59;
    localparam logic [HrsW-1:0] MaxHrs = 4'd11;

    // Request bit positions; lower index means higher service priority.
    localparam int unsigned NumReq    = 7;
    localparam int unsigned ReqTick   = 0;
    localparam int unsigned ReqSec    = 1;
    localparam int unsigned ReqMin    = 2;
    localparam int unsigned ReqHrs    = 3;
    localparam int unsigned ReqAlAdj  = 4;
    localparam int unsigned ReqToggle = 5;
    localparam int unsigned ReqSnooze = 6;

    // Increment with wrap to zero; anything at or above max wraps as well.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
        return (val >= max_val) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/time_request_sequencer_if.sv
// Request pulses and time/alarm outputs of the time request sequencer.
interface time_request_sequencer_if;
    import clock_pkg::*;

    logic            tick_1hz;
    logic            sec_adj;
    logic            min_adj;
    logic            hrs_adj;
    logic            al_adj;
    logic            al_toggle;
    logic            snooze;
    logic [SecW-1:0] seconds;
    logic [MinW-1:0] minutes;
    logic [HrsW-1:0] hours;
    logic [MinW-1:0] al_minutes;
    logic [HrsW-1:0] al_hours;
    logic            al_on;
    logic            alarm;

    modport master (
        output tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle, snooze,
        input  seconds, minutes, hours, al_minutes, al_hours, al_on, alarm
    );

    modport slave (
        input  tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle, snooze,
        output seconds, minutes, hours, al_minutes, al_hours, al_on, alarm
    );

endinterface

// File: rtl/time_request_sequencer_alarm_fsm.sv
// Alarm state machine: arming, ringing timeout and snooze countdown.
module alarm_fsm
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_svc_i,
    input  logic toggle_svc_i,
    input  logic snooze_svc_i,
    input  logic trigger_i,
    input  logic min_carry_i,
    output logic al_on_o,
    output logic alarm_o
);

    localparam int unsigned RingW = $clog2(TIMEOUT_S + 1);
    localparam int unsigned SnzW  = 6;

    alarm_state_e   state_q, state_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
    logic           al_on_q, al_on_d;
    logic           alarm_q, alarm_d;

    // Next state; at most one service strobe is active per cycle.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (toggle_svc_i) begin
            state_d = (state_q == StOff) ? StArmed : StOff;
        end else if (snooze_svc_i) begin
            if (state_q == StRinging) begin
                state_d   = StSnoozed;
                snz_cnt_d = SnzW'(SNOOZE_MIN);
            end
        end else if (tick_svc_i) begin
            unique case (state_q)
                StArmed: begin
                    if (trigger_i) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                    end
                end
                StRinging: begin
                    if (ring_cnt_q >= RingW'(TIMEOUT_S - 1)) begin
                        state_d = StArmed;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RingW'(1);
                    end
                end
                StSnoozed: begin
                    if (min_carry_i) begin
                        if (snz_cnt_q <= SnzW'(1)) begin
                            state_d    = StRinging;
                            ring_cnt_d = '0;
                            snz_cnt_d  = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - SnzW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        al_on_d = (state_d != StOff);
        alarm_d = (state_d == StRinging);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StOff;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            al_on_q    <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            al_on_q    <= al_on_d;
            alarm_q    <= alarm_d;
        end
    end

    assign al_on_o = al_on_q;
    assign alarm_o = alarm_q;

endmodule

// File: rtl/time_request_sequencer.sv
// Latches request pulses as pending bits, services one per cycle by fixed
// priority, and performs the clock/alarm-time arithmetic.
module time_request_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S  = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned AL_STEP    = 10
) (
    input logic                     clk,
    input logic                     reset_n,
    time_request_sequencer_if.slave bus
);

    logic [NumReq-1:0] req_in, pend_q, pend_d, grant;
    logic [SecW-1:0]   sec_q, sec_d;
    logic [MinW-1:0]   min_q, min_d;
    logic [HrsW-1:0]   hrs_q, hrs_d;
    logic [MinW-1:0]   al_min_q, al_min_d;
    logic [HrsW-1:0]   al_hrs_q, al_hrs_d;
    logic [6:0]        al_sum;
    logic              min_carry;
    logic              trigger;
    logic              al_on, alarm;

    assign req_in = {bus.snooze, bus.al_toggle, bus.al_adj, bus.hrs_adj,
                     bus.min_adj, bus.sec_adj, bus.tick_1hz};

    // Lowest set pending bit wins; new arrivals OR in after the grant is cleared
    // so a request landing on its own service cycle stays pending.
    always_comb begin
        grant  = pend_q & (~pend_q + NumReq'(1));
        pend_d = (pend_q & ~grant) | req_in;
    end

    // Time and alarm-time arithmetic for the granted request.
    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        hrs_d     = hrs_q;
        al_min_d  = al_min_q;
        al_hrs_d  = al_hrs_q;
        al_sum    = 7'({1'b0, al_min_q} + 7'(AL_STEP));
        min_carry = 1'b0;
        unique case (1'b1)
            grant[ReqTick]: begin
                sec_d = wrap_inc(sec_q, MaxSec);
                if (sec_q >= MaxSec) begin
                    min_carry = 1'b1;
                    min_d     = wrap_inc(min_q, MaxMin);
                    if (min_q >= MaxMin) begin
                        hrs_d = HrsW'(wrap_inc({2'b00, hrs_q}, {2'b00, MaxHrs}));
                    end
                end
            end
            grant[ReqSec]: sec_d = wrap_inc(sec_q, MaxSec);
            grant[ReqMin]: min_d = wrap_inc(min_q, MaxMin);
            grant[ReqHrs]: hrs_d = HrsW'(wrap_inc({2'b00, hrs_q}, {2'b00, MaxHrs}));
            grant[ReqAlAdj]: begin
                if (al_sum >= 7'd60) begin
                    al_min_d = MinW'(al_sum - 7'd60);
                    al_hrs_d = HrsW'(wrap_inc({2'b00, al_hrs_q}, {2'b00, MaxHrs}));
                end else begin
                    al_min_d = al_sum[MinW-1:0];
                end
            end
            default: ;
        endcase
        // Match is taken on the post-tick time; alarm fields are stable on a tick cycle.
        trigger = grant[ReqTick] && (sec_d == '0) && (min_d == al_min_q) && (hrs_d == al_hrs_q);
    end

    // Pending bits and time registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_q   <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hrs_q    <= '0;
            al_min_q <= '0;
            al_hrs_q <= '0;
        end else begin
            pend_q   <= pend_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hrs_q    <= hrs_d;
            al_min_q <= al_min_d;
            al_hrs_q <= al_hrs_d;
        end
    end

    alarm_fsm #(
        .TIMEOUT_S  (TIMEOUT_S),
        .SNOOZE_MIN (SNOOZE_MIN)
    ) u_alarm_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_svc_i   (grant[ReqTick]),
        .toggle_svc_i (grant[ReqToggle]),
        .snooze_svc_i (grant[ReqSnooze]),
        .trigger_i    (trigger),
        .min_carry_i  (min_carry),
        .al_on_o      (al_on),
        .alarm_o      (alarm)
    );

    assign bus.seconds    = sec_q;
    assign bus.minutes    = min_q;
    assign bus.hours      = hrs_q;
    assign bus.al_minutes = al_min_q;
    assign bus.al_hours   = al_hrs_q;
    assign bus.al_on      = al_on;
    assign bus.alarm      = alarm;

endmodule

// File: tb/tb_time_request_sequencer.sv
// Bench for time_request_sequencer: directed scenarios plus random requests,
// every cycle compared against a behavioural model kept as seconds-of-day.
module tb_time_request_sequencer;

    localparam int unsigned TimeoutS  = 60;
    localparam int unsigned SnoozeMin = 5;
    localparam int unsigned AlStep    = 10;

    localparam bit [6:0] RTick = 7'h01;
    localparam bit [6:0] RSec  = 7'h02;
    localparam bit [6:0] RMin  = 7'h04;
    localparam bit [6:0] RHrs  = 7'h08;
    localparam bit [6:0] RAl   = 7'h10;
    localparam bit [6:0] RTog  = 7'h20;
    localparam bit [6:0] RSnz  = 7'h40;

    localparam int MOff = 0, MArmed = 1, MRinging = 2, MSnoozed = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    // Model state: time as seconds of a 12-hour day, alarm as minutes of the day.
    int       m_t  = 0;
    int       m_al = 0;
    int       m_st = MOff;
    int       m_rc = 0;
    int       m_sc = 0;
    bit [6:0] m_pend = '0;

    always #5 clk = ~clk;

    time_request_sequencer_if bus ();

    time_request_sequencer #(
        .TIMEOUT_S  (TimeoutS),
        .SNOOZE_MIN (SnoozeMin),
        .AL_STEP    (AlStep)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit [6:0] req, input bit rst_n);
        int svc;
        int v;
        bit carry;
        if (!rst_n) begin
            m_t = 0; m_al = 0; m_st = MOff; m_rc = 0; m_sc = 0; m_pend = '0;
            return;
        end
        svc = -1;
        for (int i = 0; i < 7; i++) begin
            if (m_pend[i] && svc < 0) svc = i;
        end
        case (svc)
            0: begin
                carry = (m_t % 60 == 59);
                m_t   = (m_t + 1) % 43200;
                if (m_st == MArmed) begin
                    if (m_t % 60 == 0 && m_t / 60 == m_al) begin
                        m_st = MRinging; m_rc = 0;
                    end
                end else if (m_st == MRinging) begin
                    m_rc++;
                    if (m_rc >= TimeoutS) m_st = MArmed;
                end else if (m_st == MSnoozed && carry) begin
                    m_sc--;
                    if (m_sc == 0) begin
                        m_st = MRinging; m_rc = 0;
                    end
                end
            end
            1: begin v = m_t % 60;        m_t = m_t - v + (v + 1) % 60; end
            2: begin v = (m_t / 60) % 60; m_t = m_t - v * 60 + ((v + 1) % 60) * 60; end
            3: begin v = m_t / 3600;      m_t = m_t - v * 3600 + ((v + 1) % 12) * 3600; end
            4: m_al = (m_al + AlStep) % 720;
            5: m_st = (m_st == MOff) ? MArmed : MOff;
            6: if (m_st == MRinging) begin m_st = MSnoozed; m_sc = SnoozeMin; end
            default: ;
        endcase
        if (svc >= 0) m_pend[svc] = 1'b0;
        m_pend = m_pend | req;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        chk("seconds",    int'(bus.seconds),    m_t % 60);
        chk("minutes",    int'(bus.minutes),    (m_t / 60) % 60);
        chk("hours",      int'(bus.hours),      m_t / 3600);
        chk("al_minutes", int'(bus.al_minutes), m_al % 60);
        chk("al_hours",   int'(bus.al_hours),   m_al / 60);
        chk("al_on",      int'(bus.al_on),      (m_st != MOff) ? 1 : 0);
        chk("alarm",      int'(bus.alarm),      (m_st == MRinging) ? 1 : 0);
    end

    task automatic drive_cycle(input bit [6:0] req, input bit rst_n);
        @(negedge clk);
        reset_n       = rst_n;
        bus.tick_1hz  = req[0];
        bus.sec_adj   = req[1];
        bus.min_adj   = req[2];
        bus.hrs_adj   = req[3];
        bus.al_adj    = req[4];
        bus.al_toggle = req[5];
        bus.snooze    = req[6];
        model_step(req, rst_n);
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit [6:0] req, input int n);
        repeat (n) drive_cycle(req, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(7'h00, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sec"},   int'(bus.seconds),    0);
        chk({tag, "_min"},   int'(bus.minutes),    0);
        chk({tag, "_hrs"},   int'(bus.hours),      0);
        chk({tag, "_almin"}, int'(bus.al_minutes), 0);
        chk({tag, "_alhrs"}, int'(bus.al_hours),   0);
        chk({tag, "_alon"},  int'(bus.al_on),      0);
        chk({tag, "_alarm"}, int'(bus.alarm),      0);
    endtask

    // From reset: alarm 00:10 armed, time 00:09:59, then one tick to ring.
    task automatic ring_setup();
        pulse(RAl, 1);
        pulse(RSec, 59);
        pulse(RMin, 9);
        pulse(RTog, 1);
        idle(2);
        chk("arm_alon", int'(bus.al_on), 1);
        chk("arm_alarm", int'(bus.alarm), 0);
        chk("arm_sec", int'(bus.seconds), 59);
        pulse(RTick, 1);
        chk("ring_latency", int'(bus.alarm), 0);
        idle(1);
        chk("ring_alarm", int'(bus.alarm), 1);
        chk("ring_min", int'(bus.minutes), 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit [6:0] r;
        reset_n       = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.sec_adj   = 1'b0;
        bus.min_adj   = 1'b0;
        bus.hrs_adj   = 1'b0;
        bus.al_adj    = 1'b0;
        bus.al_toggle = 1'b0;
        bus.snooze    = 1'b0;

        // Reset beats simultaneous requests.
        drive_cycle(7'h7f, 1'b0);
        drive_cycle(7'h7f, 1'b0);
        chk_all_zero("reset");
        idle(3);
        chk_all_zero("post_reset");

        // 11:59:59 + tick -> 00:00:00 two edges later.
        pulse(RSec, 59);
        pulse(RMin, 59);
        pulse(RHrs, 11);
        idle(2);
        chk("preset_hrs", int'(bus.hours), 11);
        chk("preset_sec", int'(bus.seconds), 59);
        pulse(RTick, 1);
        chk("wrap_n1_sec", int'(bus.seconds), 59);
        idle(1);
        chk("wrap_sec", int'(bus.seconds), 0);
        chk("wrap_min", int'(bus.minutes), 0);
        chk("wrap_hrs", int'(bus.hours), 0);

        // Simultaneous tick, sec_adj, hrs_adj served one per cycle by priority.
        drive_cycle(RTick | RSec | RHrs, 1'b1);
        chk("prio_n1_sec", int'(bus.seconds), 0);
        idle(1);
        chk("prio_n2_sec", int'(bus.seconds), 1);
        idle(1);
        chk("prio_n3_sec", int'(bus.seconds), 2);
        chk("prio_n3_hrs", int'(bus.hours), 0);
        idle(1);
        chk("prio_n4_hrs", int'(bus.hours), 1);

        // Alarm time 11:50 + step -> 00:00.
        drive_cycle(7'h00, 1'b0);
        pulse(RAl, 71);
        idle(2);
        chk("al_pre_min", int'(bus.al_minutes), 50);
        chk("al_pre_hrs", int'(bus.al_hours), 11);
        pulse(RAl, 1);
        idle(1);
        chk("al_wrap_min", int'(bus.al_minutes), 0);
        chk("al_wrap_hrs", int'(bus.al_hours), 0);

        // Ring, then timeout back to armed after TimeoutS more ticks.
        drive_cycle(7'h00, 1'b0);
        ring_setup();
        pulse(RTick, TimeoutS - 1);
        idle(2);
        chk("ring_before_timeout", int'(bus.alarm), 1);
        pulse(RTick, 1);
        idle(1);
        chk("timeout_alarm", int'(bus.alarm), 0);
        chk("timeout_alon", int'(bus.al_on), 1);

        // Re-ring at 00:20, snooze, ring again after SnoozeMin minute carries.
        pulse(RAl, 1);
        pulse(RMin, 8);
        pulse(RSec, 59);
        idle(2);
        pulse(RTick, 1);
        idle(1);
        chk("rering_alarm", int'(bus.alarm), 1);
        pulse(RSnz, 1);
        idle(1);
        chk("snooze_alarm", int'(bus.alarm), 0);
        chk("snooze_alon", int'(bus.al_on), 1);
        for (int k = 1; k <= SnoozeMin; k++) begin
            pulse(RTick, 60);
            idle(2);
            chk("snooze_carry", int'(bus.alarm), (k == SnoozeMin) ? 1 : 0);
        end
        pulse(RTog, 1);
        idle(1);
        chk("toggle_off_alon", int'(bus.al_on), 0);
        chk("toggle_off_alarm", int'(bus.alarm), 0);

        // Reset while ringing with every request pending.
        drive_cycle(7'h00, 1'b0);
        ring_setup();
        pulse(RMin | RAl, 1);
        idle(2);
        chk("adjust_keeps_ring", int'(bus.alarm), 1);
        drive_cycle(7'h7f, 1'b1);
        drive_cycle(7'h7f, 1'b0);
        chk_all_zero("ring_reset");
        idle(4);
        chk_all_zero("ring_reset_idle");

        // Random traffic from a ringing start.
        ring_setup();
        for (int c = 0; c < 3000; c++) begin
            r[0] = ($urandom_range(0, 3) == 0);
            for (int b = 1; b < 7; b++) r[b] = ($urandom_range(0, 7) == 0);
            drive_cycle(r, ($urandom_range(0, 499) != 0));
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
